regfile_access_arbiter: RTL and testbench

//  Sole owner of the RAM file-register port. It forms the 9-bit file address for the core:

---
 rtl/regfile_access_arbiter_pkg.sv | 21 ++
 rtl/regfile_access_arbiter_if.sv | 41 ++++
 rtl/regfile_access_arbiter_addr_gen.sv | 20 ++
 rtl/regfile_access_arbiter.sv | 117 +++++++++++
 tb/tb_regfile_access_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_access_arbiter_pkg.sv
// Shared constants and types for the RAM file-register port arbiter.
// Holds the FSM state encodings, the INDF field value and the debug command record.
package regfile_access_arbiter_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DRD0 = 3'd1;
  localparam logic [2:0] ST_DRD1 = 3'd2;
  localparam logic [2:0] ST_DCAP = 3'd3;
  localparam logic [2:0] ST_DWR  = 3'd4;
  localparam logic [2:0] ST_DFIN = 3'd5;

  localparam logic [6:0] INDF_F_ADDR      = 7'h00;
  localparam int         DBG_READ_LATENCY = 2;

  typedef struct packed {
    logic       we;
    logic [8:0] addr;
    logic [7:0] wdata;
  } dbg_cmd_t;

endpackage

// File: rtl/regfile_access_arbiter_if.sv
// Signal bundle between the core/debug requesters, the arbiter and ram_file_registers.
// The arbiter attaches to the slave modport; the surrounding logic uses master.
interface regfile_access_arbiter_if;
  logic [6:0] core_f_addr;
  logic       core_rd_en;
  logic       core_wr_en;
  logic [7:0] core_wdata;
  logic [1:0] status_rp;
  logic       status_irp;
  logic [7:0] fsr_val;
  logic       core_stall;
  logic       core_ind_null;
  logic       dbg_req;
  logic       dbg_we;
  logic [8:0] dbg_addr;
  logic [7:0] dbg_wdata;
  logic       dbg_gnt;
  logic       dbg_done;
  logic [7:0] dbg_rdata;
  logic [8:0] rf_addr;
  logic       rf_rd_en;
  logic       rf_wr_en;
  logic [7:0] rf_wdata;
  logic [7:0] rf_rdata;

  modport master (
    output core_f_addr, core_rd_en, core_wr_en, core_wdata,
    output status_rp, status_irp, fsr_val,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, rf_rdata,
    input  core_stall, core_ind_null, dbg_gnt, dbg_done, dbg_rdata,
    input  rf_addr, rf_rd_en, rf_wr_en, rf_wdata
  );

  modport slave (
    input  core_f_addr, core_rd_en, core_wr_en, core_wdata,
    input  status_rp, status_irp, fsr_val,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, rf_rdata,
    output core_stall, core_ind_null, dbg_gnt, dbg_done, dbg_rdata,
    output rf_addr, rf_rd_en, rf_wr_en, rf_wdata
  );
endinterface

// File: rtl/regfile_access_arbiter_addr_gen.sv
// Core file-address generator: direct {RP1:RP0,f}, or indirect {IRP,FSR} when f addresses INDF.
// Flags an indirect access that lands back on INDF itself.
module regfile_addr_gen
  import regfile_access_arbiter_pkg::*;
(
  input  logic [6:0] f_addr,
  input  logic [1:0] status_rp,
  input  logic       status_irp,
  input  logic [7:0] fsr_val,
  output logic [8:0] addr,
  output logic       ind_null
);

  logic indirect;

  assign indirect = (f_addr == INDF_F_ADDR);
  assign addr     = indirect ? {status_irp, fsr_val} : {status_rp, f_addr};
  assign ind_null = indirect && (fsr_val[6:0] == INDF_F_ADDR);

endmodule

// File: rtl/regfile_access_arbiter.sv
// Owner of the RAM file-register port: core address generation plus a debug req/gnt/done side channel.
// Optional starvation guard enabled by defining REGFILE_ARB_STARVE_GUARD_EN.
module regfile_access_arbiter
  import regfile_access_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  regfile_access_arbiter_if.slave  bus
);

  logic [2:0] state, state_nxt;
  dbg_cmd_t   cmd;
  logic [7:0] rdata_q;
  logic [8:0] core_addr;
  logic       ind_null;
  logic       force_gnt;
  logic       core_owns;
  logic       gnt;

  regfile_addr_gen u_addr_gen (
    .f_addr     (bus.core_f_addr),
    .status_rp  (bus.status_rp),
    .status_irp (bus.status_irp),
    .fsr_val    (bus.fsr_val),
    .addr       (core_addr),
    .ind_null   (ind_null)
  );

`ifdef REGFILE_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  assign force_gnt = (state == ST_IDLE) && bus.dbg_req && (starve_cnt == CNT_W'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (gnt) begin
      starve_cnt <= '0;
    end else if ((state == ST_IDLE) && bus.dbg_req && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  // Without the guard, debug simply waits for a core-idle slot.
  logic unused_starve_limit;
  assign unused_starve_limit = |STARVE_LIMIT;
  assign force_gnt = 1'b0;
`endif

  // Read timing is fixed by the DRD0/DRD1 pair matching the RAM's two-cycle latency.
  logic unused_read_latency;
  assign unused_read_latency = (DBG_READ_LATENCY == 2);

  assign core_owns = (state == ST_IDLE) && !force_gnt;
  assign gnt       = (state == ST_IDLE) && bus.dbg_req &&
                     ((!bus.core_rd_en && !bus.core_wr_en) || force_gnt);

  // NOTE: every output gets a default before the case so no latch can be inferred.
  always_comb begin
    bus.rf_addr       = cmd.addr;
    bus.rf_rd_en      = 1'b0;
    bus.rf_wr_en      = 1'b0;
    bus.rf_wdata      = cmd.wdata;
    bus.core_stall    = 1'b1;
    bus.core_ind_null = 1'b0;
    bus.dbg_done      = 1'b0;
    state_nxt         = state;
    case (state)
      ST_IDLE: begin
        bus.core_stall = force_gnt;
        if (core_owns) begin
          bus.rf_addr       = core_addr;
          bus.rf_rd_en      = bus.core_rd_en;
          bus.rf_wr_en      = bus.core_wr_en && !ind_null;
          bus.rf_wdata      = bus.core_wdata;
          bus.core_ind_null = ind_null;
        end
        if (gnt) state_nxt = bus.dbg_we ? ST_DWR : ST_DRD0;
      end
      ST_DRD0: begin
        bus.rf_rd_en = 1'b1;
        state_nxt    = ST_DRD1;
      end
      ST_DRD1: state_nxt = ST_DCAP;
      ST_DCAP: state_nxt = ST_DFIN;
      ST_DWR: begin
        bus.rf_wr_en = 1'b1;
        state_nxt    = ST_DFIN;
      end
      ST_DFIN: begin
        bus.dbg_done = 1'b1;
        state_nxt    = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.dbg_gnt   = gnt;
  assign bus.dbg_rdata = rdata_q;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cmd     <= '0;
      rdata_q <= 8'h00;
    end else begin
      state <= state_nxt;
      if (gnt) cmd <= '{we: bus.dbg_we, addr: bus.dbg_addr, wdata: bus.dbg_wdata};
      if (state == ST_DCAP) rdata_q <= bus.rf_rdata;
    end
  end

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Self-checking bench for regfile_access_arbiter: directed literal cases plus a randomized run
// compared every cycle against a transaction-level model and a two-cycle-latency RAM model.
module tb_regfile_access_arbiter;
  import regfile_access_arbiter_pkg::*;

  localparam int LIMIT = 4;
`ifdef REGFILE_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_access_arbiter_if bus ();

  regfile_access_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- RAM model: write at the edge, read data two edges after rd_en ----------------
  logic [7:0] mem [512];
  logic [7:0] rd_stage;
  logic       s_wr, s_rd;
  logic [8:0] s_addr;
  logic [7:0] s_wdata;

  function automatic logic [7:0] ram_val(input logic [8:0] a);
    return (a[6:0] == 7'h00) ? 8'h00 : mem[a];
  endfunction

  always @(negedge clk) begin
    s_wr    = bus.rf_wr_en;
    s_rd    = bus.rf_rd_en;
    s_addr  = bus.rf_addr;
    s_wdata = bus.rf_wdata;
  end

  always @(posedge clk) begin
    bus.rf_rdata <= rd_stage;
    rd_stage     <= s_rd ? ram_val(s_addr) : 8'hxx;
    if (s_wr) mem[s_addr] = s_wdata;
  end

  // ---------------- transaction-level model ----------------
  int         k = 0;          // cycles elapsed since the last grant (0 = no debug transaction)
  int         wait_cnt = 0;
  bit         m_we;
  logic [8:0] m_addr;
  logic [7:0] m_wdata;
  logic [7:0] m_pending;
  logic [7:0] m_rdata = 8'h00;
  bit         g_gnt = 1'b0;

  always @(negedge clk) begin
    int         len;
    bit         busy, frc, owns, nul;
    logic [8:0] caddr;
    bit         e_rd, e_wr;
    len   = m_we ? 2 : DBG_READ_LATENCY + 2;
    busy  = (k > 0);
    frc   = GUARD && !busy && bus.dbg_req && (wait_cnt >= LIMIT);
    g_gnt = !busy && bus.dbg_req && ((!bus.core_rd_en && !bus.core_wr_en) || frc);
    owns  = !busy && !frc;
    caddr = (bus.core_f_addr != 7'h00) ? {bus.status_rp, bus.core_f_addr}
                                       : {bus.status_irp, bus.fsr_val};
    nul   = (bus.core_f_addr == 7'h00) && (bus.fsr_val[6:0] == 7'h00);
    e_rd  = owns ? bus.core_rd_en : (busy && k == 1 && !m_we);
    e_wr  = owns ? (bus.core_wr_en && !nul) : (busy && k == 1 && m_we);
    if (rst === 1'b0) begin
      check("m_stall",    32'(bus.core_stall),    32'(busy || frc));
      check("m_gnt",      32'(bus.dbg_gnt),       32'(g_gnt));
      check("m_done",     32'(bus.dbg_done),      32'(busy && k == len));
      check("m_rdata",    32'(bus.dbg_rdata),     32'(m_rdata));
      check("m_ind_null", 32'(bus.core_ind_null), 32'(owns && nul));
      check("m_rd_en",    32'(bus.rf_rd_en),      32'(e_rd));
      check("m_wr_en",    32'(bus.rf_wr_en),      32'(e_wr));
      if (e_rd || e_wr) check("m_addr", 32'(bus.rf_addr), 32'(owns ? caddr : m_addr));
      if (e_wr) check("m_wdata", 32'(bus.rf_wdata), 32'(owns ? bus.core_wdata : m_wdata));
    end
  end

  always @(posedge clk) begin
    int len;
    len = m_we ? 2 : DBG_READ_LATENCY + 2;
    if (rst) begin
      k = 0; wait_cnt = 0; m_rdata = 8'h00;
    end else if (g_gnt) begin
      k = 1; wait_cnt = 0;
      m_we = bus.dbg_we; m_addr = bus.dbg_addr; m_wdata = bus.dbg_wdata;
      m_pending = ram_val(bus.dbg_addr);
    end else if (k > 0) begin
      if (!m_we && k == len - 1) m_rdata = m_pending;
      k = (k == len) ? 0 : k + 1;
    end else if (bus.dbg_req) begin
      wait_cnt = (wait_cnt < LIMIT) ? wait_cnt + 1 : LIMIT;
    end
  end

  // ---------------- stimulus ----------------
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic core_idle();
    bus.core_rd_en = 1'b0;
    bus.core_wr_en = 1'b0;
  endtask

  initial begin
    int gnt_at;
    for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[9'h0C0] = 8'h3C;
    rd_stage = 8'h00;
    bus.rf_rdata = 8'h00;
    bus.core_f_addr = 7'h00; bus.core_wdata = 8'h00;
    bus.status_rp = 2'b00; bus.status_irp = 1'b0; bus.fsr_val = 8'h01;
    core_idle();
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = 9'h000; bus.dbg_wdata = 8'h00;
    rst = 1'b1;
    next(); next();
    rst = 1'b0;

    @(negedge clk);
    check("rst_stall", 32'(bus.core_stall), 32'h0);
    check("rst_gnt",   32'(bus.dbg_gnt),    32'h0);
    check("rst_done",  32'(bus.dbg_done),   32'h0);
    check("rst_rdata", 32'(bus.dbg_rdata),  32'h00);
    next();

    // Direct core read
    bus.core_f_addr = 7'h20; bus.status_rp = 2'b01; bus.core_rd_en = 1'b1;
    @(negedge clk);
    check("t1_addr",  32'(bus.rf_addr),    32'h0A0);
    check("t1_rd",    32'(bus.rf_rd_en),   32'h1);
    check("t1_stall", 32'(bus.core_stall), 32'h0);
    next();

    // Indirect core write, then indirect onto INDF itself
    bus.core_rd_en = 1'b0; bus.core_wr_en = 1'b1; bus.core_f_addr = 7'h00;
    bus.status_irp = 1'b1; bus.fsr_val = 8'h25; bus.core_wdata = 8'h11;
    @(negedge clk);
    check("t2_addr", 32'(bus.rf_addr),  32'h125);
    check("t2_wr",   32'(bus.rf_wr_en), 32'h1);
    next();
    bus.fsr_val = 8'h80;
    @(negedge clk);
    check("t2_null",    32'(bus.core_ind_null), 32'h1);
    check("t2_null_wr", 32'(bus.rf_wr_en),      32'h0);
    next();
    core_idle();

    // Debug write 9'h070 <= 8'hA5
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 9'h070; bus.dbg_wdata = 8'hA5;
    @(negedge clk);
    check("t3_gnt", 32'(bus.dbg_gnt), 32'h1);
    next();
    bus.dbg_req = 1'b0;
    @(negedge clk);
    check("t3_wr",    32'(bus.rf_wr_en),   32'h1);
    check("t3_waddr", 32'(bus.rf_addr),    32'h070);
    check("t3_stall", 32'(bus.core_stall), 32'h1);
    next();
    @(negedge clk);
    check("t3_done", 32'(bus.dbg_done), 32'h1);
    next();
    bus.core_f_addr = 7'h70; bus.status_rp = 2'b00; bus.core_rd_en = 1'b1;
    next();
    core_idle();
    next();
    @(negedge clk);
    check("t3_readback", 32'(bus.rf_rdata), 32'hA5);
    next();

    // Debug read of 9'h0C0
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 9'h0C0;
    @(negedge clk);
    check("t4_gnt",    32'(bus.dbg_gnt),    32'h1);
    check("t4_stall0", 32'(bus.core_stall), 32'h0);
    next();
    bus.dbg_req = 1'b0;
    @(negedge clk);
    check("t4_rd",     32'(bus.rf_rd_en),   32'h1);
    check("t4_stall1", 32'(bus.core_stall), 32'h1);
    next();
    @(negedge clk);
    check("t4_stall2", 32'(bus.core_stall), 32'h1);
    next();
    @(negedge clk);
    check("t4_stall3", 32'(bus.core_stall), 32'h1);
    check("t4_nodone", 32'(bus.dbg_done),   32'h0);
    next();
    @(negedge clk);
    check("t4_done",  32'(bus.dbg_done),  32'h1);
    check("t4_rdata", 32'(bus.dbg_rdata), 32'h3C);
    next();
    @(negedge clk);
    check("t4_release", 32'(bus.core_stall), 32'h0);
    next();

    // Core wins contention; grant only once the core goes idle
    bus.core_rd_en = 1'b1; bus.core_f_addr = 7'h30;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 9'h1F3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_core_wins", 32'(bus.dbg_gnt), 32'h0);
      next();
    end
    core_idle();
    @(negedge clk);
    check("t5_gnt_idle", 32'(bus.dbg_gnt), 32'h1);
    next();
    bus.dbg_req = 1'b0;
    next();
    rst = 1'b1;                         // held through DRD1
    next();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_rst_stall", 32'(bus.core_stall), 32'h0);
      check("t5_rst_done",  32'(bus.dbg_done),   32'h0);
      next();
    end

    // Core busy every cycle with debug request held
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 9'h055; bus.dbg_wdata = 8'h77;
    gnt_at = -1;
    for (int i = 0; i < 100; i++) begin
      bus.core_rd_en = 1'b1; bus.core_f_addr = 7'($urandom_range(1, 127));
      @(negedge clk);
      if (bus.dbg_gnt === 1'b1) begin
        gnt_at = i;
        check("t6_forced_stall", 32'(bus.core_stall), 32'h1);
        check("t6_masked_rd",    32'(bus.rf_rd_en),   32'h0);
      end
      next();
      if (gnt_at >= 0) break;
    end
    check("t6_gnt_cycle", 32'(gnt_at), GUARD ? 32'(LIMIT) : 32'hFFFF_FFFF);
    core_idle();
    bus.dbg_req = 1'b0;
    for (int i = 0; i < 4; i++) next();

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int r;
      r = $urandom_range(0, 9);
      bus.core_rd_en  = (r < 4);
      bus.core_wr_en  = (r >= 4 && r < 6);
      bus.core_wdata  = 8'($urandom);
      bus.core_f_addr = ($urandom_range(0, 3) == 0) ? 7'h00 : 7'($urandom);
      bus.status_rp   = 2'($urandom);
      bus.status_irp  = 1'($urandom);
      bus.fsr_val     = ($urandom_range(0, 3) == 0) ? {1'($urandom), 7'h00} : 8'($urandom);
      if (bus.dbg_req && g_gnt) begin
        bus.dbg_req = 1'b0;
      end else if (!bus.dbg_req && $urandom_range(0, 7) == 0) begin
        bus.dbg_req   = 1'b1;
        bus.dbg_we    = 1'($urandom);
        bus.dbg_addr  = 9'($urandom);
        bus.dbg_wdata = 8'($urandom);
      end
      next();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
